// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment code table, nibble codes and frame FSM states
package seven_seg_pkg;

    // Active-low segment codes, bit6=a ... bit0=g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIB_BLANK   = 4'hF;
    localparam logic [3:0] NIB_INVALID = 4'hE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2
    } frame_state_t;

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// rtl/seven_seg_pattern_decoder.sv - segment pattern to decimal nibble, inverse of the decimal driver
module seven_seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        nibble  = NIB_INVALID;
        invalid = 1'b0;
        case (seg_in)
            SEG_0:     nibble = 4'd0;
            SEG_1:     nibble = 4'd1;
            SEG_2:     nibble = 4'd2;
            SEG_3:     nibble = 4'd3;
            SEG_4:     nibble = 4'd4;
            SEG_5:     nibble = 4'd5;
            SEG_6:     nibble = 4'd6;
            SEG_7:     nibble = 4'd7;
            SEG_8:     nibble = 4'd8;
            SEG_9:     nibble = 4'd9;
            SEG_BLANK: nibble = NIB_BLANK;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// rtl/seven_seg_scan_reader.sv - samples a scanned seven-segment bus and presents one decoded frame per scan
module seven_seg_scan_reader
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic [DIGITS-1:0]     digit_en,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     err_mask,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  timeout_pulse
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCW   = $clog2(STABLE_CYCLES + 1);
    localparam int TCW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCW-1:0]   SC_MAX   = SCW'(STABLE_CYCLES);
    localparam logic [SCW-1:0]   SC_ARM   = SCW'(STABLE_CYCLES - 1);
    localparam logic [TCW-1:0]   TC_LAST  = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [DIGITS-1:0]   prev_en;
    logic [6:0]          prev_seg;
    logic [SCW-1:0]      stab_cnt;
    logic                strobe, same, capture;
    logic [IDX_W-1:0]    cap_idx;
    logic [3:0]          nibble;
    logic                invalid;

    frame_state_t        state, state_next;
    logic [IDX_W-1:0]    expect_idx, expect_next;
    logic [TCW-1:0]      tcnt, tcnt_next;
    logic                store, load, tout;
    logic [4*DIGITS-1:0] shadow_bcd, frame_bcd;
    logic [DIGITS-1:0]   shadow_err, frame_err;

    seven_seg_pattern_decoder u_decoder (
        .seg_in  (seg_in),
        .nibble  (nibble),
        .invalid (invalid)
    );

    always_comb begin
        strobe  = (digit_en != '0) && ((digit_en & (digit_en - DIGITS'(1))) == '0);
        same    = (digit_en == prev_en) && (seg_in == prev_seg);
        // Fires on the cycle the count steps to STABLE_CYCLES, so only once per unchanged strobe
        capture = strobe && same && (stab_cnt == SC_ARM);
        cap_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_en[i]) cap_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_en  <= '0;
            prev_seg <= '0;
            stab_cnt <= '0;
        end else begin
            prev_en  <= digit_en;
            prev_seg <= seg_in;
            if (!strobe)                stab_cnt <= '0;
            else if (!same)             stab_cnt <= SCW'(1);
            else if (stab_cnt != SC_MAX) stab_cnt <= stab_cnt + SCW'(1);
        end
    end

    // Complete frame as it would look with the current capture merged in
    always_comb begin
        frame_bcd = shadow_bcd;
        frame_err = shadow_err;
        frame_bcd[{cap_idx, 2'b00} +: 4] = nibble;
        frame_err[cap_idx] = invalid;
    end

    always_comb begin
        state_next  = state;
        expect_next = expect_idx;
        tcnt_next   = tcnt;
        store       = 1'b0;
        load        = 1'b0;
        tout        = 1'b0;
        case (state)
            IDLE: begin
                tcnt_next = '0;
                if (capture && cap_idx == '0) begin
                    store = 1'b1;
                    if (DIGITS == 1) begin
                        load       = 1'b1;
                        state_next = PRESENT;
                    end else begin
                        expect_next = IDX_W'(1);
                        state_next  = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (capture) begin
                    tcnt_next = '0;
                    if (cap_idx == expect_idx) begin
                        store = 1'b1;
                        if (expect_idx == LAST_IDX) begin
                            load       = 1'b1;
                            state_next = PRESENT;
                        end else begin
                            expect_next = expect_idx + IDX_W'(1);
                        end
                    end else if (cap_idx == '0) begin
                        store       = 1'b1;
                        expect_next = IDX_W'(1);
                    end else begin
                        state_next = IDLE;
                    end
                end else if (tcnt == TC_LAST) begin
                    tcnt_next  = '0;
                    tout       = 1'b1;
                    state_next = IDLE;
                end else begin
                    tcnt_next = tcnt + TCW'(1);
                end
            end
            PRESENT: begin
                if (frame_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            expect_idx <= '0;
            tcnt       <= '0;
        end else begin
            state      <= state_next;
            expect_idx <= expect_next;
            tcnt       <= tcnt_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_bcd    <= '0;
            shadow_err    <= '0;
            bcd_out       <= '0;
            err_mask      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= tout;
            if (store) begin
                shadow_bcd <= frame_bcd;
                shadow_err <= frame_err;
            end
            if (load) begin
                bcd_out  <= frame_bcd;
                err_mask <= frame_err;
            end
        end
    end

    assign frame_valid = (state == PRESENT);

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// tb/tb_seven_seg_scan_reader.sv - self-checking bench for seven_seg_scan_reader and its pattern decoder
module tb_seven_seg_scan_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  digit_en;
    logic [15:0] bcd_out;
    logic [3:0]  err_mask;
    logic        frame_valid;
    logic        frame_ready;
    logic        timeout_pulse;

    logic [6:0]  dec_seg;
    logic [3:0]  dec_nib;
    logic        dec_inv;

    int total = 0;
    int bad   = 0;

    logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

    seven_seg_scan_reader #(.DIGITS(4), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (
        .clk           (clk),
        .rst           (rst),
        .seg_in        (seg_in),
        .digit_en      (digit_en),
        .bcd_out       (bcd_out),
        .err_mask      (err_mask),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .timeout_pulse (timeout_pulse)
    );

    seven_seg_pattern_decoder u_dec (
        .seg_in  (dec_seg),
        .nibble  (dec_nib),
        .invalid (dec_inv)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] model_decode(input logic [6:0] s);
        for (int d = 0; d < 10; d++) if (codes[d] == s) return {1'b0, 4'(d)};
        if (s == 7'h7F) return {1'b0, 4'hF};
        return {1'b1, 4'hE};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_digit(input int idx, input logic [6:0] s, input int n, input int gap);
        for (int c = 0; c < n; c++) begin
            digit_en = 4'(1 << idx);
            seg_in   = s;
            step();
        end
        digit_en = '0;
        for (int c = 0; c < gap; c++) step();
    endtask

    task automatic send_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        send_digit(0, s0, 6, 2);
        send_digit(1, s1, 6, 2);
        send_digit(2, s2, 6, 2);
        send_digit(3, s3, 6, 2);
    endtask

    task automatic handshake();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    initial begin
        logic [6:0]  segs [4];
        int          durs [4];
        logic [15:0] exp_bcd;
        logic [3:0]  exp_err;
        logic        exp_valid;
        logic [4:0]  m;
        logic        stable_ok;
        int          pulse_at, pulse_len;

        // Decoder: exhaustive over all patterns
        for (int v = 0; v < 128; v++) begin
            dec_seg = 7'(v);
            #1;
            m = model_decode(7'(v));
            check("dec_nibble", {28'd0, dec_nib}, {28'd0, m[3:0]});
            check("dec_invalid", {31'd0, dec_inv}, {31'd0, m[4]});
        end

        // Reset held with random inputs
        rst = 1'b1; frame_ready = 1'b0; seg_in = '0; digit_en = '0;
        for (int c = 0; c < 6; c++) begin
            seg_in   = 7'($urandom);
            digit_en = 4'($urandom);
            frame_ready = 1'($urandom);
            step();
            check("rst_bcd", {16'd0, bcd_out}, 32'd0);
            check("rst_valid", {31'd0, frame_valid}, 32'd0);
        end
        check("rst_err", {28'd0, err_mask}, 32'd0);
        rst = 1'b0; frame_ready = 1'b0; digit_en = '0; seg_in = 7'h7F;
        step(); step();

        // Clean frame 3,1,5,0 with latency check on the last digit
        send_digit(0, 7'b0000110, 6, 2);
        send_digit(1, 7'b1001111, 6, 2);
        send_digit(2, 7'b0100100, 6, 2);
        for (int c = 1; c <= 6; c++) begin
            digit_en = 4'b1000;
            seg_in   = 7'b0000001;
            step();
            if (c == 3) check("latency_early", {31'd0, frame_valid}, 32'd0);
            if (c == 4) check("latency_rise", {31'd0, frame_valid}, 32'd1);
        end
        digit_en = '0;
        check("clean_bcd", {16'd0, bcd_out}, 32'h0513);
        check("clean_err", {28'd0, err_mask}, 32'd0);
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bcd_out !== 16'h0513 || frame_valid !== 1'b1 || err_mask !== 4'd0) stable_ok = 1'b0;
        end
        check("hold_stable", {31'd0, stable_ok}, 32'd1);
        handshake();
        check("handshake_drop", {31'd0, frame_valid}, 32'd0);
        check("persist_bcd", {16'd0, bcd_out}, 32'h0513);

        // Asynchronous reset between clock edges
        send_frame(codes[1], codes[2], codes[3], codes[4]);
        check("pre_async_bcd", {16'd0, bcd_out}, 32'h4321);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_bcd", {16'd0, bcd_out}, 32'd0);
        check("async_valid", {31'd0, frame_valid}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Glitch on digit0: 8 for 3 cycles then 9
        digit_en = 4'b0001;
        seg_in   = 7'b0000000;
        step(); step(); step();
        send_digit(0, 7'b0001100, 5, 2);
        send_digit(1, codes[1], 6, 2);
        send_digit(2, codes[2], 6, 2);
        send_digit(3, codes[3], 6, 2);
        check("glitch_valid", {31'd0, frame_valid}, 32'd1);
        check("glitch_bcd", {16'd0, bcd_out}, 32'h3219);
        handshake();
        // Short digit1 strobe: no capture, frame never completes
        send_digit(0, codes[5], 6, 2);
        send_digit(1, codes[6], 3, 2);
        send_digit(2, codes[7], 6, 2);
        send_digit(3, codes[8], 6, 2);
        check("short_no_valid", {31'd0, frame_valid}, 32'd0);

        // Invalid and blank
        send_frame(7'b0000001, 7'b0000001, 7'b1111110, 7'b1111111);
        check("inv_bcd", {16'd0, bcd_out}, 32'hFE00);
        check("inv_err", {28'd0, err_mask}, 32'b0100);
        handshake();

        // Out-of-order capture discards the frame
        send_digit(0, codes[9], 6, 2);
        send_digit(2, codes[9], 6, 2);
        send_digit(3, codes[9], 6, 2);
        check("skip_no_valid", {31'd0, frame_valid}, 32'd0);
        send_frame(codes[8], codes[6], codes[0], codes[2]);
        check("after_skip_bcd", {16'd0, bcd_out}, 32'h2068);
        check("after_skip_err", {28'd0, err_mask}, 32'd0);
        handshake();

        // Timeout: capture digit0 then idle
        for (int c = 0; c < 4; c++) begin
            digit_en = 4'b0001; seg_in = codes[1]; step();
        end
        digit_en = '0;
        pulse_at = -1; pulse_len = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (timeout_pulse === 1'b1) begin
                if (pulse_at < 0) pulse_at = k;
                pulse_len++;
            end
        end
        check("timeout_at", pulse_at, 1024);
        check("timeout_len", pulse_len, 1);
        send_digit(1, codes[1], 6, 2);
        send_digit(2, codes[1], 6, 2);
        send_digit(3, codes[1], 6, 2);
        check("timeout_idle", {31'd0, frame_valid}, 32'd0);

        // Reset mid-frame
        send_digit(0, codes[7], 6, 2);
        send_digit(1, codes[6], 6, 2);
        rst = 1'b1;
        #2;
        check("midrst_bcd", {16'd0, bcd_out}, 32'd0);
        check("midrst_err", {28'd0, err_mask}, 32'd0);
        step();
        rst = 1'b0;
        step();
        send_digit(2, codes[4], 6, 2);
        send_digit(3, codes[2], 6, 2);
        check("midrst_no_stale", {31'd0, frame_valid}, 32'd0);
        send_frame(codes[7], codes[6], codes[4], codes[2]);
        check("midrst_bcd_new", {16'd0, bcd_out}, 32'h2467);
        handshake();

        // Randomized frames against the behavioural model
        for (int f = 0; f < 20; f++) begin
            exp_valid = 1'b1;
            exp_bcd   = '0;
            exp_err   = '0;
            for (int d = 0; d < 4; d++) begin
                int r;
                r = $urandom_range(0, 11);
                if (r < 10) segs[d] = codes[r];
                else if (r == 10) segs[d] = 7'h7F;
                else begin
                    segs[d] = 7'($urandom);
                    while (model_decode(segs[d]) != 5'h1E) segs[d] = 7'($urandom);
                end
                durs[d] = $urandom_range(3, 7);
                if (durs[d] < 4) exp_valid = 1'b0;
                m = model_decode(segs[d]);
                exp_bcd[4*d +: 4] = m[3:0];
                exp_err[d]        = m[4];
            end
            for (int d = 0; d < 4; d++) send_digit(d, segs[d], durs[d], $urandom_range(1, 2));
            check("rand_valid", {31'd0, frame_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("rand_bcd", {16'd0, bcd_out}, {16'd0, exp_bcd});
                check("rand_err", {28'd0, err_mask}, {28'd0, exp_err});
            end
            if (frame_valid === 1'b1) handshake();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
Receive side of the seven-segment display path. It samples a multiplexed, scanned seven-segment bus and decodes each segment pattern back to a decimal digit. It assembles one value per scan frame and presents it on a valid/ready interface. Uses: self-checking display loopback, and reading displays driven by the decimal seven-segment driver.

Parameters:
DIGITS, 4, number of scanned digit positions; digit 0 is least significant.
STABLE_CYCLES, 4, consecutive identical cycles required before a digit is captured; must be at least 2.
TIMEOUT_CYCLES, 1024, maximum cycles between captures inside a frame before the frame is abandoned.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
seg_in  input  7  segment bus, active-low; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; synchronous to clk
digit_en  input  DIGITS  digit strobe, active-high; one-hot or zero
bcd_out  output  4*DIGITS  captured nibbles; nibble i is at [4i+3:4i]
err_mask  output  DIGITS  bit i set means digit i held an invalid pattern
frame_valid  output  1  bcd_out and err_mask hold a complete frame
frame_ready  input  1  consumer accepts the frame
timeout_pulse  output  1  one-cycle pulse when a frame is abandoned on timeout

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all counters 0; bcd_out=0, err_mask=0, frame_valid=0, timeout_pulse=0. Reset asserted mid-frame discards the partial frame.
- Pattern decode (combinational):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
  - 1111111 (blank) decodes to 4'hF, no error.
  - Any other pattern decodes to 4'hE and sets the error flag.
- Stability filter:
  - A strobe cycle is one where digit_en is exactly one-hot.
  - Counter increments while the current {digit_en, seg_in} equals the previous cycle's value and the cycle is a strobe cycle.
  - Counter resets to 1 on any change. It resets to 0 on zero or multi-hot digit_en.
  - A capture event fires on the cycle the count reaches STABLE_CYCLES. It fires only once per unchanged strobe; a new capture needs a change first.
  - Capture index = position of the set bit in digit_en.
- Frame FSM:
  - IDLE:
    - Capture at index 0: store the nibble and error bit, set expect=1, go to COLLECT.
    - Capture at any other index: ignored.
  - COLLECT:
    - Capture at index == expect: store it and increment expect. If expect was DIGITS-1, go to PRESENT.
    - Capture at any other index: discard the frame. If that index is 0, restart with it (store, expect=1). Otherwise go to IDLE.
    - Timeout counter clears on each capture. If it reaches TIMEOUT_CYCLES: go to IDLE and assert timeout_pulse for 1 cycle.
  - PRESENT:
    - frame_valid=1; bcd_out and err_mask are held stable.
    - Captures are ignored (frame dropped) and the stability filter keeps running.
    - When frame_valid && frame_ready on a clock edge: go to IDLE; frame_valid is 0 the next cycle.
  - DIGITS=1: a capture in IDLE goes directly to PRESENT.
- Latency: frame_valid rises the cycle after the capture event of digit DIGITS-1.
- bcd_out and err_mask are updated only when entering PRESENT. Partial frames never appear on the outputs. Previous values persist after the handshake.
- Width rules:
  - Stability counter is clog2(STABLE_CYCLES+1) bits and saturates.
  - Timeout counter is clog2(TIMEOUT_CYCLES+1) bits.
  - expect is clog2(DIGITS) bits, minimum 1 bit.

Decomposition:
- Shared package seven_seg_pkg contains:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - NIB_BLANK=4'hF and NIB_INVALID=4'hE;
  - the frame FSM state enum (IDLE, COLLECT, PRESENT).
- The driver and this reader share the constants, so encode and decode tables cannot diverge.
- One sub-module: seven_seg_pattern_decoder, combinational, seg_in[6:0] to nibble[3:0] plus invalid. It is the exact inverse of the decimal driver and is unit-tested exhaustively over all 128 inputs.

Test Plan:
1. Reset: hold rst high with random seg_in/digit_en → bcd_out=0, err_mask=0, frame_valid=0. Assert rst asynchronously between clock edges → outputs clear without a clock edge.
2. Clean frame (DIGITS=4, STABLE_CYCLES=4):
   - Stimulus: each digit strobed for 6 cycles, 2 zero-strobe cycles between digits. Digit0 = 0000110, digit1 = 1001111, digit2 = 0100100, digit3 = 0000001.
   - Response: frame_valid=1 one cycle after digit3's capture; bcd_out=16'h0513, err_mask=0.
   - Hold frame_ready=0 for 10 cycles → outputs stable. Pulse frame_ready → frame_valid=0 next cycle.
3. Glitch rejection: digit0 = 0000000 for 3 cycles, then 0001100 for 5 cycles → nibble0=9, not 8. Digit1 held for only 3 cycles → no capture; frame not completed.
4. Invalid and blank: digit2 = 1111110, digit3 = 1111111, digits 0 and 1 = 0000001 → bcd_out=16'hFE00, err_mask=4'b0100.
5. Sequencing:
   - Capture digit0 then digit2 → frame discarded, no frame_valid. The following clean frame is reported correctly.
   - Capture digit0, then idle for 1024 cycles → timeout_pulse high for exactly 1 cycle, state IDLE.
6. Reset mid-frame: after digits 0 and 1 are captured, pulse rst → outputs 0. The next full frame 7,6,4,2 → bcd_out=16'h2467, and no stale nibbles appear.
